// File: rtl/edge_sched_pkg.sv
// Shared definitions for the edge event TX scheduler.
//   state_t        : scheduler FSM encoding
//   RISE/FALL_CODE : default upper-nibble codes for rise/fall bytes
//   N_SRC_*        : source count default and legal bounds
//   IDX_W          : width of the source index field inside tx_data
package edge_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  localparam logic [7:0] RISE_CODE_DEF = 8'h50;
  localparam logic [7:0] FALL_CODE_DEF = 8'h40;

  localparam int N_SRC_DEF = 4;
  localparam int N_SRC_MIN = 2;
  localparam int N_SRC_MAX = 16;

  // Index field is sized for the largest legal source count.
  localparam int IDX_W = $clog2(N_SRC_MAX);

endpackage

// File: rtl/edge_event_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : per-source request vector
//   ptr : highest-priority index for this decision
//   gnt : one-hot grant (all zero when no request)
//   idx : binary index of the granted source
//   vld : at least one request present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  // Two passes instead of a modulo rotate: first look at ptr..N-1, then
  // wrap to 0..ptr-1. The second pass can only hit below ptr because the
  // first pass already covered everything at or above it.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!vld && req[j] && (j >= int'(ptr))) begin
        gnt[j] = 1'b1;
        idx    = IW'(j);
        vld    = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!vld && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IW'(j);
        vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_event_tx_scheduler.sv
// Edge event TX scheduler: detects rise/fall edges on N_SRC level inputs,
// queues one rise and one fall per source, and feeds them one byte at a
// time to a UART transmitter in round-robin source order.
//   clk, reset    : clock, synchronous active-high reset
//   evt_level     : synchronised level inputs
//   evt_en        : per-source edge-detect enable
//   tx_ready      : transmitter can accept a byte
//   tx_done_tick  : transmitter finished the current byte
//   ovf_clr       : per-source clear of the overflow flag
//   tx_start      : one-cycle send request
//   tx_data       : {code nibble, source index}, held until the next grant
//   busy          : FSM not idle
//   ovf           : sticky per-source lost-event flag
module edge_event_tx_scheduler
  import edge_sched_pkg::*;
#(
  parameter int         N_SRC     = N_SRC_DEF,
  parameter logic [7:0] RISE_CODE = RISE_CODE_DEF,
  parameter logic [7:0] FALL_CODE = FALL_CODE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] evt_level,
  input  logic [N_SRC-1:0] evt_en,
  input  logic             tx_ready,
  input  logic             tx_done_tick,
  input  logic [N_SRC-1:0] ovf_clr,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic [N_SRC-1:0] ovf
);

  localparam int IW = $clog2(N_SRC);

  state_t           state;
  logic [N_SRC-1:0] prev, rise_pend, fall_pend;
  logic [N_SRC-1:0] rise_evt, fall_evt, ovf_evt;
  logic [N_SRC-1:0] req, gnt, srv_rise, srv_fall;
  logic [IW-1:0]    ptr, cur_idx, arb_idx;
  logic             arb_vld, grant_fire, srv_is_rise;

  assign rise_evt = evt_en & ~prev &  evt_level;
  assign fall_evt = evt_en &  prev & ~evt_level;
  assign req      = rise_pend | fall_pend;

  rr_arbiter #(.N(N_SRC), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  assign grant_fire = (state == ST_IDLE) && tx_ready && arb_vld;

  // Rise has priority inside the granted source; exactly one bit is served.
  assign srv_rise    = {N_SRC{grant_fire}} & gnt & rise_pend;
  assign srv_fall    = {N_SRC{grant_fire}} & gnt & ~rise_pend & fall_pend;
  assign srv_is_rise = |srv_rise;

  // A new event only counts as lost when its bit is still owed and is not
  // being handed out on this very edge; otherwise it simply re-arms.
  assign ovf_evt = (rise_evt & rise_pend & ~srv_rise) |
                   (fall_evt & fall_pend & ~srv_fall);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev      <= '0;
      rise_pend <= '0;
      fall_pend <= '0;
      ovf       <= '0;
    end else begin
      prev      <= evt_level;
      rise_pend <= rise_evt | (rise_pend & ~srv_rise);
      fall_pend <= fall_evt | (fall_pend & ~srv_fall);
      // Set beats clear when both land on the same edge.
      ovf       <= ovf_evt | (ovf & ~ovf_clr);
    end
  end

  // ptr is the first index searched; after a byte completes it moves to
  // the slot just past the source that was served.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cur_idx  <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_start <= 1'b0;
          if (grant_fire) begin
            state    <= ST_START;
            cur_idx  <= arb_idx;
            tx_data  <= {srv_is_rise ? RISE_CODE[7:4] : FALL_CODE[7:4],
                         IDX_W'(arb_idx)};
            tx_start <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_START: begin
          tx_start <= 1'b0;
          state    <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          tx_start <= 1'b0;
          if (tx_done_tick) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            ptr   <= (cur_idx == IW'(N_SRC - 1)) ? '0 : cur_idx + IW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          tx_start <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
